// File: rtl/x_uart_pkg.sv
// rtl/x_uart_pkg.sv - shared UART framing constants and transmitter state type
//
// Purpose: common definitions for the UART word transmitter and its helpers.
// Contents:
//   uart_state_t     - transmitter FSM states (IDLE, START, DATA, STOP)
//   UART_DATA_BITS   - data bits per frame
//   UART_FRAME_BITS  - total bits per frame (start + data + stop)
//   UART_IDLE_LEVEL  - line level while no frame is in flight
package x_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_FRAME_BITS = 10;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/x_uart_baud_tick.sv
// rtl/x_uart_baud_tick.sv - bit-period counter producing a tick on the last cycle of each bit
//
// Purpose: divides the system clock into UART bit periods; used by both the
//          transmit and receive sides.
// Ports:
//   i_clk  - system clock
//   i_rst  - asynchronous active-high reset
//   i_en   - count enable; counter is held at zero while low
//   o_tick - high on the last cycle of each CLKS_PER_BIT-cycle bit period
module x_uart_baud_tick #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Clearing while disabled means the first enabled cycle is always
    // cycle 0 of a fresh bit period.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (!i_en || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_tick = i_en && (cnt == CNT_LAST);

endmodule

// File: rtl/x_uart_word_tx.sv
// rtl/x_uart_word_tx.sv - UART transmitter sending one multi-byte word as back-to-back 8N1 frames
//
// Purpose: accepts a word over a valid/ready handshake and serializes it LSB
//          byte first, LSB bit first, as BYTES consecutive 8N1 frames.
// Ports:
//   i_clk   - system clock
//   i_rst   - asynchronous active-high reset
//   i_data  - word to send (8*BYTES bits), sampled only on acceptance
//   i_valid - word available
//   o_ready - idle, a word is accepted this cycle if i_valid is high
//   o_tx    - serial line, idle high, driven from a flop
//   o_busy  - high in every non-idle state
module x_uart_word_tx
    import x_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int BYTES        = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [8*BYTES-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_busy
);

    localparam int                 WORD_W    = 8 * BYTES;
    localparam int                 BYTE_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BYTE_W-1:0]  LAST_BYTE = BYTE_W'(BYTES - 1);
    localparam logic [2:0]         LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_t       state;
    uart_state_t       state_nx;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nx;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic              tick;
    logic              accept;
    logic              baud_en;
    logic              tx_nx;

    assign accept  = (state == IDLE) && i_valid;
    assign baud_en = (state != IDLE);

    x_uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (baud_en),
        .o_tick(tick)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept)                        state_nx = START;
            START: if (tick)                          state_nx = DATA;
            DATA:  if (tick && bit_cnt == LAST_BIT)   state_nx = STOP;
            STOP:  if (tick)                          state_nx = (byte_cnt == LAST_BYTE) ? IDLE : START;
            default:                                  state_nx = IDLE;
        endcase
    end

    // The word shifts right one bit per data bit, so the bit on the line is
    // always shreg[0] and the next byte lands at the bottom after 8 shifts.
    always_comb begin
        shreg_nx = shreg;
        if (accept) begin
            shreg_nx = i_data;
        end else if (state == DATA && tick) begin
            shreg_nx = shreg >> 1;
        end
    end

    // Output logic. The line level is computed from the next state so the
    // registered o_tx already shows the start bit on the cycle after acceptance.
    always_comb begin
        o_ready = (state == IDLE);
        o_busy  = (state != IDLE);
        tx_nx   = UART_IDLE_LEVEL;
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shreg_nx[0];
            default: tx_nx = UART_IDLE_LEVEL;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shreg    <= '0;
            o_tx     <= UART_IDLE_LEVEL;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            shreg <= shreg_nx;
            o_tx  <= tx_nx;

            if (accept || (state == START && tick)) begin
                bit_cnt <= '0;
            end else if (state == DATA && tick) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (accept) begin
                byte_cnt <= '0;
            end else if (state == STOP && tick && byte_cnt != LAST_BYTE) begin
                byte_cnt <= byte_cnt + BYTE_W'(1);
            end
        end
    end

endmodule
